// File: rtl/apb_periph_bank.sv
// apb_periph_bank: three-slot APB slave bank (register file, down-counting timer, FIFO)
// Every access completes in the setup/enable pair; reads are combinational, writes and pops commit on the enable edge.
module apb_periph_bank #(
  parameter int RF_DEPTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pirq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [3:0] idx;
  logic valid, wr, rd_com, s0, s1, s2;
  logic unused_addr;
  assign idx = Paddr[5:2];
  assign unused_addr = ^{Paddr[31:6], Paddr[1:0]};
  assign valid = (Pselx == 3'b001) || (Pselx == 3'b010) || (Pselx == 3'b100);
  assign s0 = valid & Pselx[0];
  assign s1 = valid & Pselx[1];
  assign s2 = valid & Pselx[2];
  assign wr = valid & Penable & Pwrite;
  assign rd_com = valid & Penable & ~Pwrite;
  logic [31:0] rf_q [RF_DEPTH];
  logic [31:0] rf_d [RF_DEPTH];
  logic        rf_hit;
  assign rf_hit = 32'(idx) < RF_DEPTH;
  logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d, exp_q, exp_d;
  logic [31:0] load_q, load_d, count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          empty, full, push_req, pop_req, push, pop;
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign push_req = wr & s2 & (idx == 4'd0);
  assign pop_req  = rd_com & s2 & (idx == 4'd0);
  assign push     = push_req & ~full;
  assign pop      = pop_req & ~empty;
  always_comb begin
    rf_d = rf_q;
    if (wr && s0 && rf_hit) rf_d[idx] = Pwdata;
  end
  // Order matters: W1C first so a same-edge expiry wins; CTRL/LOAD writes last so they win over the timer.
  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    if (wr && s1 && idx == 4'd3 && Pwdata[0]) exp_d = 1'b0;
    if (en_q) begin
      if (count_q != '0) count_d = count_q - 32'd1;
      else begin
        exp_d = 1'b1;
        if (auto_q) count_d = load_q;
        else en_d = 1'b0;
      end
    end
    if (wr && s1 && idx == 4'd0) {ie_d, auto_d, en_d} = Pwdata[2:0];
    if (wr && s1 && idx == 4'd1) begin
      load_d  = Pwdata;
      count_d = Pwdata;
    end
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = Pwdata;
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = (ovf_q & ~(wr & s2 & idx == 4'd1 & Pwdata[6])) | (push_req & full);
    unf_d = (unf_q & ~(wr & s2 & idx == 4'd1 & Pwdata[7])) | (pop_req & empty);
  end
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      rf_q    <= '{default: '0};
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rf_q    <= rf_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      load_q  <= load_d;
      count_q <= count_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  logic [31:0] rf_rd, tmr_rd, fifo_rd, fifo_status;
  assign fifo_status = {24'b0, unf_q, ovf_q, full, empty, 4'(cnt_q)};
  always_comb begin
    rf_rd   = rf_hit ? rf_q[idx] : '0;
    tmr_rd  = idx == 4'd0 ? {29'b0, ie_q, auto_q, en_q} :
              idx == 4'd1 ? load_q :
              idx == 4'd2 ? count_q :
              idx == 4'd3 ? {31'b0, exp_q} : '0;
    fifo_rd = idx == 4'd0 ? (empty ? '0 : mem_q[rp_q]) :
              idx == 4'd1 ? fifo_status : '0;
    Prdata  = !(valid && !Pwrite) ? '0 : s0 ? rf_rd : s1 ? tmr_rd : fifo_rd;
  end
  assign Pirq = (exp_q & ie_q) | ovf_q | unf_q;
endmodule

// File: tb/tb_apb_periph_bank.sv
// tb_apb_periph_bank: scoreboard bench for the APB peripheral bank
// Expected values are queued when stimulus is issued and popped as each observation is taken.
module tb_apb_periph_bank;
  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic        Pirq;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb [$];

  always #5 Hclk = ~Hclk;

  apb_periph_bank #(.RF_DEPTH(16), .FIFO_DEPTH(8)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Pirq(Pirq)
  );

  task automatic idle();
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
  endtask

  task automatic apb_write(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    @(posedge Hclk); #1 Pselx = s; Paddr = a; Pwdata = d; Pwrite = 1'b1; Penable = 1'b0;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(posedge Hclk); #1 idle();
  endtask

  task automatic apb_read(input logic [2:0] s, input logic [31:0] a, output logic [31:0] d);
    @(posedge Hclk); #1 Pselx = s; Paddr = a; Pwrite = 1'b0; Penable = 1'b0;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(negedge Hclk); d = Prdata;
    @(posedge Hclk); #1 idle();
  endtask

  task automatic test_reset();
    logic [31:0] obs, e;
    idle();
    Hreset = 1'b1;
    repeat (2) @(posedge Hclk);
    #1 Hreset = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'h0);
    @(negedge Hclk);
    e = sb.pop_front(); vectors++;
    if (Prdata !== e) begin miscompares++; $display("FAIL rst_prdata got %h want %h", Prdata, e); end
    e = sb.pop_front(); vectors++;
    if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL rst_pirq got %h want %h", Pirq, e); end
    sb.push_back(32'h10); apb_read(3'b100, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rst_fifo_status got %h want %h", obs, e); end
    sb.push_back(32'h0); apb_read(3'b010, 32'h8, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rst_count got %h want %h", obs, e); end
  endtask

  task automatic test_regfile();
    logic [31:0] obs, e;
    logic [31:0] addrs [3] = '{32'h08, 32'h0C, 32'hFFFF_FF3C};
    logic [31:0] want  [3] = '{32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D};
    apb_write(3'b001, 32'h08, 32'hDEAD_BEEF);
    apb_write(3'b001, 32'hFFFF_FF3C, 32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(want[i]);
      apb_read(3'b001, addrs[i], obs);
      e = sb.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rf_read[%0d] got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] e;
    apb_write(3'b010, 32'h4, 32'd3);
    apb_write(3'b010, 32'h0, 32'h5);
    Pselx = 3'b010; Paddr = 32'h8; Pwrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(32'(3 - i)); sb.push_back(32'h0);
      @(negedge Hclk);
      e = sb.pop_front(); vectors++;
      if (Prdata !== e) begin miscompares++; $display("FAIL oneshot_count[%0d] got %h want %h", i, Prdata, e); end
      e = sb.pop_front(); vectors++;
      if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL oneshot_pirq_early[%0d] got %h want %h", i, Pirq, e); end
    end
    sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h1); sb.push_back(32'h4);
    @(negedge Hclk);
    e = sb.pop_front(); vectors++;
    if (Prdata !== e) begin miscompares++; $display("FAIL oneshot_count_hold got %h want %h", Prdata, e); end
    e = sb.pop_front(); vectors++;
    if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL oneshot_pirq got %h want %h", Pirq, e); end
    Paddr = 32'hC; #1;
    e = sb.pop_front(); vectors++;
    if (Prdata !== e) begin miscompares++; $display("FAIL oneshot_exp got %h want %h", Prdata, e); end
    Paddr = 32'h0; #1;
    e = sb.pop_front(); vectors++;
    if (Prdata !== e) begin miscompares++; $display("FAIL oneshot_ctrl got %h want %h", Prdata, e); end
    idle();
  endtask

  task automatic test_timer_w1c();
    logic [31:0] obs, e;
    apb_write(3'b010, 32'hC, 32'h1);
    sb.push_back(32'h0); apb_read(3'b010, 32'hC, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL w1c_exp got %h want %h", obs, e); end
    sb.push_back(32'h0); @(negedge Hclk);
    e = sb.pop_front(); vectors++;
    if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL w1c_pirq got %h want %h", Pirq, e); end
  endtask

  task automatic test_timer_auto();
    logic [31:0] e;
    apb_write(3'b010, 32'h4, 32'd2);
    apb_write(3'b010, 32'h0, 32'h7);
    Pselx = 3'b010; Paddr = 32'h8; Pwrite = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(32'(2 - (i % 3))); sb.push_back(i >= 3 ? 32'h1 : 32'h0);
      @(negedge Hclk);
      e = sb.pop_front(); vectors++;
      if (Prdata !== e) begin miscompares++; $display("FAIL auto_count[%0d] got %h want %h", i, Prdata, e); end
      e = sb.pop_front(); vectors++;
      if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL auto_pirq[%0d] got %h want %h", i, Pirq, e); end
    end
    idle();
    apb_write(3'b010, 32'h0, 32'h0);
    apb_write(3'b010, 32'hC, 32'h1);
  endtask

  task automatic test_fifo();
    logic [31:0] obs, e;
    for (int i = 1; i <= 9; i++) apb_write(3'b100, 32'h0, 32'(i));
    sb.push_back(32'h68); apb_read(3'b100, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL fifo_full_status got %h want %h", obs, e); end
    sb.push_back(32'h1); @(negedge Hclk);
    e = sb.pop_front(); vectors++;
    if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL fifo_ovf_pirq got %h want %h", Pirq, e); end
    apb_write(3'b100, 32'h4, 32'h40);
    sb.push_back(32'h0); @(negedge Hclk);
    e = sb.pop_front(); vectors++;
    if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL fifo_ovf_clear_pirq got %h want %h", Pirq, e); end
    for (int i = 1; i <= 9; i++) begin
      sb.push_back(i <= 8 ? 32'(i) : 32'h0);
      apb_read(3'b100, 32'h0, obs);
      e = sb.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL fifo_pop[%0d] got %h want %h", i, obs, e); end
    end
    sb.push_back(32'h90); apb_read(3'b100, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL fifo_unf_status got %h want %h", obs, e); end
    sb.push_back(32'h1); @(negedge Hclk);
    e = sb.pop_front(); vectors++;
    if ({31'b0, Pirq} !== e) begin miscompares++; $display("FAIL fifo_unf_pirq got %h want %h", Pirq, e); end
    apb_write(3'b100, 32'h4, 32'h80);
    sb.push_back(32'h10); apb_read(3'b100, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL fifo_unf_clear got %h want %h", obs, e); end
  endtask

  task automatic test_bad_select();
    logic [31:0] obs, e;
    apb_write(3'b011, 32'h4, 32'h1234);
    apb_write(3'b110, 32'h0, 32'h55);
    sb.push_back(32'h0); apb_read(3'b001, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL badsel_rf got %h want %h", obs, e); end
    sb.push_back(32'h2); apb_read(3'b010, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL badsel_load got %h want %h", obs, e); end
    sb.push_back(32'h10); apb_read(3'b100, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL badsel_fifo got %h want %h", obs, e); end
    sb.push_back(32'h0); apb_read(3'b011, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL badsel_prdata got %h want %h", obs, e); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] obs, e;
    apb_write(3'b100, 32'h0, 32'hAA);
    @(posedge Hclk); #1 Pselx = 3'b100; Paddr = 32'h0; Pwdata = 32'hBB; Pwrite = 1'b1; Penable = 1'b0;
    @(negedge Hclk); Hreset = 1'b1;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(posedge Hclk); #1 idle(); Hreset = 1'b0;
    sb.push_back(32'h10); apb_read(3'b100, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL midrst_fifo got %h want %h", obs, e); end
    sb.push_back(32'h0); apb_read(3'b001, 32'h8, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL midrst_rf got %h want %h", obs, e); end
    sb.push_back(32'h0); apb_read(3'b010, 32'h4, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL midrst_load got %h want %h", obs, e); end
    apb_write(3'b100, 32'h0, 32'hCC);
    sb.push_back(32'hCC); apb_read(3'b100, 32'h0, obs);
    e = sb.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL midrst_push_after got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_timer_oneshot();
    test_timer_w1c();
    test_timer_auto();
    test_fifo();
    test_bad_select();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
